// File: rtl/encoder.sv
// Segment encoder: turns controller header/status requests and datapath blocks into a stream of
// command/data words through a single registered output stage.
module encoder #(
  parameter int unsigned BUS_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                from_cntrl_head_req,
  input  logic [3:0]          from_cntrl_dtype,
  input  logic                from_cntrl_eot,
  input  logic                from_cntrl_last,
  input  logic [15:0]         from_cntrl_length,
  input  logic                from_cntrl_status_req,
  input  logic                from_cntrl_success,
  output logic                to_cntrl_ready,
  output logic                to_cntrl_seg_done,
  input  logic [BUS_SIZE-1:0] from_dp_data,
  input  logic                from_dp_data_valid,
  output logic                to_dp_ready,
  output logic [BUS_SIZE-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready
);

  localparam int unsigned BYTES = BUS_SIZE / 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned HDR_W = 32;
  localparam logic [HDR_W-1:0] STATUS_OK  = 32'hE000_0000;
  localparam logic [HDR_W-1:0] STATUS_ERR = 32'hF000_0000;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA, S_STATUS} state_e;

  state_e              state_q, state_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic                success_q, success_d;

  logic                out_free;
  logic                head_acc;
  logic                stat_acc;
  logic                dp_acc;
  logic                last_word;
  logic [BUS_SIZE-1:0] masked;

  assign out_free          = !valid_q || data_out_ready;
  assign to_cntrl_ready    = !rst && (state_q == S_IDLE) && out_free;
  assign to_dp_ready       = !rst && (state_q == S_DATA) && out_free;
  assign head_acc          = to_cntrl_ready && from_cntrl_head_req;
  assign stat_acc          = to_cntrl_ready && from_cntrl_status_req && !from_cntrl_head_req;
  assign dp_acc            = to_dp_ready && from_dp_data_valid;
  assign last_word         = (rem_q <= CNT_W'(BYTES));
  assign to_cntrl_seg_done = dp_acc && last_word;
  assign data_out          = data_q;
  assign data_out_valid    = valid_q;

  // Bytes at or beyond the remaining count (byte 0 in the MSBs) are zeroed.
  always_comb begin
    masked = from_dp_data;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (CNT_W'(i) >= rem_q) masked[BUS_SIZE-1-8*i -: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rem_q     <= '0;
      hdr_q     <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rem_q     <= rem_d;
      hdr_q     <= hdr_d;
      success_q <= success_d;
    end
  end

  // Next-state selection; a header request wins over a simultaneous status request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (head_acc)      state_d = S_HEAD;
        else if (stat_acc) state_d = S_STATUS;
      end
      S_HEAD:   if (out_free) state_d = (rem_q != '0) ? S_DATA : S_IDLE;
      S_DATA:   if (dp_acc && last_word) state_d = S_IDLE;
      S_STATUS: if (out_free) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output stage and segment bookkeeping.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q && !data_out_ready;
    rem_d     = rem_q;
    hdr_d     = hdr_q;
    success_d = success_q;
    if (head_acc) begin
      hdr_d = {from_cntrl_dtype, 1'b0, from_cntrl_eot, from_cntrl_last, 1'b0, 8'h00,
               from_cntrl_length};
      rem_d = from_cntrl_length;
    end
    if (stat_acc) success_d = from_cntrl_success;
    if ((state_q == S_HEAD) && out_free) begin
      data_d                     = '0;
      data_d[BUS_SIZE-1 -: HDR_W] = hdr_q;
      valid_d                    = 1'b1;
    end
    if ((state_q == S_STATUS) && out_free) begin
      data_d                     = '0;
      data_d[BUS_SIZE-1 -: HDR_W] = success_q ? STATUS_OK : STATUS_ERR;
      valid_d                    = 1'b1;
    end
    if (dp_acc) begin
      data_d  = masked;
      valid_d = 1'b1;
      rem_d   = last_word ? '0 : rem_q - CNT_W'(BYTES);
    end
  end

endmodule

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 Parameter: BUS_SIZE, default 32, width of the output bus and of the datapath words; SHALL be a multiple of 8 and at least 32; BUSdiv8 = BUS_SIZE/8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 from_cntrl_head_req  input  1  controller requests emission of an output header; held high until accepted.
REQ-005 from_cntrl_dtype  input  4  segment data type for the requested header.
REQ-006 from_cntrl_eot  input  1  end-of-type flag for the requested header.
REQ-007 from_cntrl_last  input  1  last flag for the requested header.
REQ-008 from_cntrl_length  input  16  segment length in bytes for the requested header.
REQ-009 from_cntrl_status_req  input  1  controller requests emission of a status word; held high until accepted.
REQ-010 from_cntrl_success  input  1  status polarity: 1 = success, 0 = failure.
REQ-011 to_cntrl_ready  output  1  encoder is able to accept a header or status request this cycle.
REQ-012 to_cntrl_seg_done  output  1  one-cycle pulse when the last data word of a segment is accepted.
REQ-013 from_dp_data  input  BUS_SIZE  datapath output block; byte 0 in bits [BUS_SIZE-1:BUS_SIZE-8].
REQ-014 from_dp_data_valid  input  1  from_dp_data is valid.
REQ-015 to_dp_ready  output  1  encoder accepts from_dp_data this cycle.
REQ-016 data_out  output  BUS_SIZE  output command/data word.
REQ-017 data_out_valid  output  1  data_out is valid.
REQ-018 data_out_ready  input  1  downstream accepts data_out.

Function
REQ-019 FSM states: IDLE, HEAD, DATA, STATUS; data_out/data_out_valid SHALL be registered (one-entry output stage).
REQ-020 Output stage free = !data_out_valid | data_out_ready; a word transfers when data_out_valid & data_out_ready.
REQ-021 to_cntrl_ready = (state==IDLE) & output stage free.
REQ-022 IDLE, to_cntrl_ready & head_req: latch dtype/eot/last/length into header register and remaining counter, go HEAD; head_req SHALL win over a simultaneous status_req (status stays pending).
REQ-023 IDLE, to_cntrl_ready & status_req & !head_req: latch success, go STATUS.
REQ-024 HEAD, output stage free: load header word {dtype, 1'b0, eot, last, 8'h00, length} in the upper 32 bits, lower BUS_SIZE-32 bits zero; data_out_valid=1; next state DATA if length!=0 else IDLE.
REQ-025 STATUS, output stage free: load 32'hE000_0000 (success) or 32'hF000_0000 (failure), upper-aligned, lower bits zero; data_out_valid=1; next IDLE.
REQ-026 DATA: to_dp_ready = output stage free; on from_dp_data_valid & to_dp_ready, load masked word, data_out_valid=1, remaining -= BUSdiv8.
REQ-027 Masking: if remaining >= BUSdiv8 all bytes pass; else bytes with index >= remaining SHALL be forced to 8'h00.
REQ-028 Accepted word with remaining <= BUSdiv8 is last: pulse to_cntrl_seg_done same cycle as acceptance, counter cleared to 0, next IDLE.
REQ-029 to_dp_ready SHALL be 0 in every state other than DATA; from_dp_data outside DATA is ignored.
REQ-030 When no new word is loaded and data_out_ready=1, data_out_valid SHALL drop to 0; data_out SHALL hold while data_out_valid & !data_out_ready.
REQ-031 Throughput: one word per cycle sustained with data_out_ready held high; header emitted one cycle after acceptance.
REQ-032 Remaining counter 16 bits, never decremented below 0 (no wrap).

Reset
REQ-033 rst=1 at any clock edge, including mid-segment: state=IDLE, data_out_valid=0, data_out=0, remaining=0, latched header/status cleared, to_cntrl_seg_done=0; to_dp_ready=0 during reset.
REQ-034 First request SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-035 head_req dtype=4'h4, eot=1, last=1, length=16'd6, BUS_SIZE=32 -> data_out 32'h4600_0006, then dp 0x11223344 -> 0x11223344, then dp 0x55667788 -> 0x55660000 with seg_done pulse, state IDLE.
REQ-036 length=16'd0 header -> single header word, no to_dp_ready assertion, to_cntrl_ready high again next cycle.
REQ-037 data_out_ready low 3 cycles mid-DATA -> data_out stable, to_dp_ready=0, no word lost or duplicated after release.
REQ-038 head_req and status_req same cycle (success=0) -> header segment emitted first, then 32'hF000_0000.
REQ-039 rst asserted after 1 of 4 data words -> data_out_valid=0 next cycle, state IDLE, new header accepted cleanly.
REQ-040 length=16'd8 with continuous dp_valid and data_out_ready=1 -> header + 2 data words on 3 consecutive cycles.
